// File: rtl/fft16_tw_scheduler.sv
// Sequences the 32 radix-2 DIT butterflies of a 16-point FFT, 8 per stage over 4 stages, and emits twiddle ROM addresses.
// Outputs are registered, first butterfly one cycle after start; a stall holds the sequence, and each stage is followed by GAP idle cycles.
module fft16_tw_scheduler #(
  parameter int GAP = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stall,
  input  logic       i_abort,
  output logic [2:0] o_tw_addr,
  output logic [3:0] o_idx_a,
  output logic [3:0] o_idx_b,
  output logic [1:0] o_stage,
  output logic       o_bf_valid,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_s, w_s_nxt;
  logic [3:0] r_k, w_k_nxt;  // k=8 marks a finished stage still waiting for its gap or done
  logic [3:0] r_gap, w_gap_nxt;
  logic       w_present, w_clear;
  logic [2:0] w_tw_nxt;
  logic [3:0] w_a_nxt, w_b_nxt;
  logic [1:0] w_stage_nxt;
  logic       w_valid_nxt, w_done_nxt;

  function automatic logic [10:0] bf_addr(input logic [1:0] s, input logic [2:0] k);
    logic [2:0] pos, grp, tw;
    logic [3:0] a, b;
    pos = k & ((3'd1 << s) - 3'd1);
    grp = k >> s;
    a   = ({1'b0, grp} << ({1'b0, s} + 3'd1)) + {1'b0, pos};
    b   = a + (4'd1 << s);
    tw  = pos << (2'd3 - s);
    return {a, b, tw};
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_k_nxt     = r_k;
    w_gap_nxt   = r_gap;
    w_present   = 1'b0;
    w_clear     = 1'b0;
    w_tw_nxt    = o_tw_addr;
    w_a_nxt     = o_idx_a;
    w_b_nxt     = o_idx_b;
    w_stage_nxt = o_stage;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_nxt = ST_RUN;
          w_s_nxt     = 2'd0;
          w_k_nxt     = 4'd0;
          w_present   = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_clear = 1'b1;
        end else if (r_k[3]) begin
          if (r_s == 2'd3) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_GAP;
            w_gap_nxt   = 4'(GAP - 1);
          end
        end else begin
          w_present = 1'b1;
        end
      end
      ST_GAP: begin
        if (i_abort) begin
          w_clear = 1'b1;
        end else if (r_gap == 4'd0) begin
          w_state_nxt = ST_RUN;
          w_s_nxt     = r_s + 2'd1;
          w_k_nxt     = 4'd0;
          w_present   = 1'b1;
        end else begin
          w_gap_nxt = r_gap - 4'd1;
        end
      end
      default: w_clear = 1'b1;
    endcase

    if (w_clear) begin
      w_state_nxt = ST_IDLE;
      w_s_nxt     = 2'd0;
      w_k_nxt     = 4'd0;
      w_gap_nxt   = 4'd0;
      w_tw_nxt    = 3'd0;
      w_a_nxt     = 4'd0;
      w_b_nxt     = 4'd0;
      w_stage_nxt = 2'd0;
    end

    // A stall only withholds the pending butterfly; the pointer advances once it is actually shown.
    if (w_present && !i_stall) begin
      w_valid_nxt                   = 1'b1;
      {w_a_nxt, w_b_nxt, w_tw_nxt}  = bf_addr(w_s_nxt, w_k_nxt[2:0]);
      w_stage_nxt                   = w_s_nxt;
      if (w_k_nxt[2:0] != 3'd7) begin
        w_k_nxt = w_k_nxt + 4'd1;
      end else if (w_s_nxt == 2'd3 || GAP != 0) begin
        w_k_nxt = 4'd8;
      end else begin
        w_s_nxt = w_s_nxt + 2'd1;
        w_k_nxt = 4'd0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_s        <= 2'd0;
      r_k        <= 4'd0;
      r_gap      <= 4'd0;
      o_tw_addr  <= 3'd0;
      o_idx_a    <= 4'd0;
      o_idx_b    <= 4'd0;
      o_stage    <= 2'd0;
      o_bf_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s        <= w_s_nxt;
      r_k        <= w_k_nxt;
      r_gap      <= w_gap_nxt;
      o_tw_addr  <= w_tw_nxt;
      o_idx_a    <= w_a_nxt;
      o_idx_b    <= w_b_nxt;
      o_stage    <= w_stage_nxt;
      o_bf_valid <= w_valid_nxt;
      o_busy     <= (w_state_nxt != ST_IDLE);
      o_done     <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_fft16_tw_scheduler.sv
// Bench for fft16_tw_scheduler: GAP=2 and GAP=0 instances share stimulus; directed traces, address table, stall/abort/reset cases, random stalls vs a butterfly-order model.
module tb_fft16_tw_scheduler;
  logic clk = 1'b0;
  logic rst, start, stall, abort;
  logic [2:0] tw2, tw0;
  logic [3:0] a2, b2, a0, b0;
  logic [1:0] st2, st0;
  logic v2, busy2, done2, v0, busy0, done0;

  int n_checks = 0;
  int n_errors = 0;

  fft16_tw_scheduler #(.GAP(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stall(stall), .i_abort(abort),
    .o_tw_addr(tw2), .o_idx_a(a2), .o_idx_b(b2), .o_stage(st2),
    .o_bf_valid(v2), .o_busy(busy2), .o_done(done2));

  fft16_tw_scheduler #(.GAP(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stall(stall), .i_abort(abort),
    .o_tw_addr(tw0), .o_idx_a(a0), .o_idx_b(b0), .o_stage(st0),
    .o_bf_valid(v0), .o_busy(busy0), .o_done(done0));

  always #5 clk = ~clk;

  typedef struct {int s; int k; int a; int b; int tw;} vec_t;
  vec_t tbl[6];

  int cap_a[32], cap_b[32], cap_tw[32], cap_s[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Butterfly n of the transform in plain arithmetic: stage s pairs elements span apart inside blocks of 2*span.
  task automatic ref_bf(input int n, output int s, output int a, output int b, output int tw);
    int k, span;
    s    = n / 8;
    k    = n % 8;
    span = 1 << s;
    a    = (k / span) * 2 * span + (k % span);
    b    = a + span;
    tw   = (k % span) * (8 / span);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_v2"}, {31'd0, v2}, 0);       chk({tag, "_busy2"}, {31'd0, busy2}, 0);
    chk({tag, "_done2"}, {31'd0, done2}, 0); chk({tag, "_a2"}, {28'd0, a2}, 0);
    chk({tag, "_b2"}, {28'd0, b2}, 0);       chk({tag, "_tw2"}, {29'd0, tw2}, 0);
    chk({tag, "_st2"}, {30'd0, st2}, 0);     chk({tag, "_v0"}, {31'd0, v0}, 0);
    chk({tag, "_busy0"}, {31'd0, busy0}, 0); chk({tag, "_a0"}, {28'd0, a0}, 0);
  endtask

  task automatic wait_done2(input int first_cyc, output int done_cyc);
    done_cyc = -1;
    for (int c = first_cyc; c < first_cyc + 80; c++) begin
      tick();
      if (done2) begin
        done_cyc = c;
        break;
      end
    end
    if (done_cyc < 0) chk("done_timeout", 1, 0);
  endtask

  initial begin
    int ncap, exp_s, exp_a, exp_b, exp_tw, dc, n, last_v, cyc;
    bit got_done, s_edge, saw_done;

    tbl = '{'{1, 5, 9, 11, 4}, '{2, 6, 10, 14, 4}, '{3, 7, 7, 15, 7},
            '{0, 3, 6, 7, 0}, '{0, 7, 14, 15, 0}, '{2, 1, 1, 5, 2}};

    rst = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy2}, 0);

    // Unstalled traces for both gap settings.
    start = 1'b1;
    ncap = 0;
    for (int c = 1; c <= 42; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("g2_valid_c%0d", c), {31'd0, v2},
          ((c >= 1 && c <= 8) || (c >= 11 && c <= 18) || (c >= 21 && c <= 28) || (c >= 31 && c <= 38)) ? 1 : 0);
      chk($sformatf("g2_done_c%0d", c), {31'd0, done2}, (c == 39) ? 1 : 0);
      chk($sformatf("g2_busy_c%0d", c), {31'd0, busy2}, (c <= 39) ? 1 : 0);
      chk($sformatf("g0_valid_c%0d", c), {31'd0, v0}, (c <= 32) ? 1 : 0);
      chk($sformatf("g0_done_c%0d", c), {31'd0, done0}, (c == 33) ? 1 : 0);
      chk($sformatf("g0_busy_c%0d", c), {31'd0, busy0}, (c <= 33) ? 1 : 0);
      if (v2 && ncap < 32) begin
        cap_a[ncap] = int'(a2); cap_b[ncap] = int'(b2);
        cap_tw[ncap] = int'(tw2); cap_s[ncap] = int'(st2);
        ncap++;
      end
    end
    chk("capture_count", ncap, 32);
    for (int i = 0; i < 32; i++) begin
      ref_bf(i, exp_s, exp_a, exp_b, exp_tw);
      chk($sformatf("order%0d_s", i), cap_s[i], exp_s);
      chk($sformatf("order%0d_a", i), cap_a[i], exp_a);
      chk($sformatf("order%0d_b", i), cap_b[i], exp_b);
      chk($sformatf("order%0d_tw", i), cap_tw[i], exp_tw);
    end
    for (int i = 0; i < 6; i++) begin
      n = tbl[i].s * 8 + tbl[i].k;
      chk($sformatf("tbl_s%0dk%0d_a", tbl[i].s, tbl[i].k), cap_a[n], tbl[i].a);
      chk($sformatf("tbl_s%0dk%0d_b", tbl[i].s, tbl[i].k), cap_b[n], tbl[i].b);
      chk($sformatf("tbl_s%0dk%0d_tw", tbl[i].s, tbl[i].k), cap_tw[n], tbl[i].tw);
    end

    // Stall for 3 cycles while (1,3) is the pending butterfly.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("stall_pre_v", {31'd0, v2}, 1);
    chk("stall_pre_a", {28'd0, a2}, 4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_v", i), {31'd0, v2}, 0);
      chk($sformatf("stall%0d_a", i), {28'd0, a2}, 4);
      chk($sformatf("stall%0d_b", i), {28'd0, b2}, 6);
      chk($sformatf("stall%0d_st", i), {30'd0, st2}, 1);
      chk($sformatf("stall%0d_busy", i), {31'd0, busy2}, 1);
    end
    stall = 1'b0;
    tick();
    chk("resume_v", {31'd0, v2}, 1);
    chk("resume_a", {28'd0, a2}, 5);
    chk("resume_b", {28'd0, b2}, 7);
    chk("resume_tw", {29'd0, tw2}, 4);
    wait_done2(18, dc);
    chk("stall_done_cycle", dc, 42);
    tick();

    // Abort while (2,4) is on the outputs.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (24) tick();
    chk("abort_pre_st", {30'd0, st2}, 2);
    chk("abort_pre_a", {28'd0, a2}, 8);
    chk("abort_pre_b", {28'd0, b2}, 12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy2}, 0);
    chk("abort_valid", {31'd0, v2}, 0);
    chk("abort_done", {31'd0, done2}, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done2 || busy2) saw_done = 1'b1;
    end
    chk("abort_quiet", {31'd0, saw_done}, 0);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy2", {31'd0, busy2}, 0);
    chk("start_abort_idle_busy0", {31'd0, busy0}, 0);

    // Fresh start after abort, with extra start pulses mid-run.
    start = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      tick();
      start = (c == 4 || c == 14 || c == 38) ? 1'b1 : 1'b0;
      if (c == 1) begin
        chk("restart_st", {30'd0, st2}, 0);
        chk("restart_a", {28'd0, a2}, 0);
        chk("restart_b", {28'd0, b2}, 1);
      end
      chk($sformatf("repulse_valid_c%0d", c), {31'd0, v2},
          ((c >= 1 && c <= 8) || (c >= 11 && c <= 18) || (c >= 21 && c <= 28) || (c >= 31 && c <= 38)) ? 1 : 0);
      chk($sformatf("repulse_done_c%0d", c), {31'd0, done2}, (c == 39) ? 1 : 0);
    end
    start = 1'b0;
    tick();

    // Asynchronous reset between clock edges.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pre_arst_busy", {31'd0, busy2}, 1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("arst");
    rst = 1'b0;
    tick();
    chk("post_arst_busy", {31'd0, busy2}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_arst_v", {31'd0, v2}, 1);
    chk("post_arst_st", {30'd0, st2}, 0);
    chk("post_arst_a", {28'd0, a2}, 0);
    wait_done2(2, dc);
    chk("post_arst_done_cycle", dc, 39);
    tick();

    // Random stalls and ignored start pulses against the butterfly-order model.
    for (int run = 0; run < 6; run++) begin
      n = 0; last_v = -10; got_done = 1'b0;
      start = 1'b1;
      stall = ($urandom_range(0, 2) == 0);
      for (cyc = 1; cyc < 400; cyc++) begin
        s_edge = stall;
        tick();
        start = 1'b0;
        if (s_edge) chk($sformatf("rnd%0d_stall_c%0d", run, cyc), {31'd0, v2}, 0);
        if (v2) begin
          last_v = cyc;
          if (n < 32) begin
            ref_bf(n, exp_s, exp_a, exp_b, exp_tw);
            chk($sformatf("rnd%0d_n%0d_s", run, n), {30'd0, st2}, exp_s);
            chk($sformatf("rnd%0d_n%0d_a", run, n), {28'd0, a2}, exp_a);
            chk($sformatf("rnd%0d_n%0d_b", run, n), {28'd0, b2}, exp_b);
            chk($sformatf("rnd%0d_n%0d_tw", run, n), {29'd0, tw2}, exp_tw);
          end
          n++;
        end
        if (done2) begin
          got_done = 1'b1;
          break;
        end
        stall = ($urandom_range(0, 2) == 0);
        start = ($urandom_range(0, 7) == 0);
      end
      stall = 1'b0;
      start = 1'b0;
      chk($sformatf("rnd%0d_got_done", run), {31'd0, got_done}, 1);
      chk($sformatf("rnd%0d_count", run), n, 32);
      chk($sformatf("rnd%0d_done_after_last", run), cyc - last_v, 1);
      tick();
      chk($sformatf("rnd%0d_idle", run), {31'd0, busy2}, 0);
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fft16_tw_scheduler.md
FFT16_TW_SCHEDULER -- requirements
Module: fft16_tw_scheduler

Interface
REQ-001 SHALL have parameter GAP, default 2, meaning idle cycles inserted between consecutive stages; legal range 0..15.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port i_start, input, 1, single-cycle request to begin one 16-point transform.
REQ-005 SHALL have port i_stall, input, 1, holds the sequence when high (downstream not ready).
REQ-006 SHALL have port i_abort, input, 1, synchronous cancel of a running transform.
REQ-007 SHALL have port o_tw_addr, output, 3, twiddle ROM address (W16^addr) feeding the 8-entry twiddle ROM.
REQ-008 SHALL have ports o_idx_a and o_idx_b, output, 4 each, butterfly upper and lower operand indices.
REQ-009 SHALL have port o_stage, output, 2, current stage 0..3.
REQ-010 SHALL have port o_bf_valid, output, 1, butterfly operands and twiddle address are valid this cycle.
REQ-011 SHALL have ports o_busy and o_done, output, 1 each: transform in progress, and a one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, GAP, DONE; all outputs registered.
REQ-013 IDLE: i_start=1 -> RUN with s=0, k=0; otherwise stay.
REQ-014 RUN: each cycle with i_stall=0 presents butterfly (s,k) with o_bf_valid=1, then advances k.
REQ-015 RUN with i_stall=1: o_bf_valid=0; s, k and index outputs hold; no advance.
REQ-016 Address arithmetic, radix-2 DIT with bit-reversed input: pos = k & (2^s-1); grp = k >> s.
REQ-016a idx_a = grp*2^(s+1) + pos; idx_b = idx_a + 2^s; tw_addr = pos << (3-s); all unsigned, no overflow beyond 4 bits.
REQ-017 After k=7 is presented in stage s<3: GAP > 0 -> GAP state for exactly GAP cycles with o_bf_valid=0, then RUN with s+1, k=0; GAP = 0 -> straight to RUN with s+1, k=0.
REQ-018 i_stall SHALL be ignored in GAP; the gap counter always decrements.
REQ-019 After (s=3, k=7) is presented -> DONE for one cycle: o_done=1, o_bf_valid=0, then IDLE.
REQ-020 o_busy SHALL be 1 in RUN, GAP and DONE, and 0 in IDLE.
REQ-021 i_start while o_busy=1 SHALL be ignored, with no restart and no queuing.
REQ-022 i_abort=1 in RUN/GAP -> IDLE next cycle, o_done not asserted, s/k cleared; i_abort has priority over i_stall.
REQ-023 i_abort in DONE SHALL be ignored; i_abort in IDLE SHALL be a no-op and SHALL take priority over a simultaneous i_start (stay IDLE).
REQ-024 Unstalled latency: i_start at cycle 0 -> first valid at cycle 1, done pulse at cycle 33+3*GAP; 32 valid butterflies total.

Reset
REQ-025 i_rst=1 SHALL immediately force IDLE, s=0, k=0, the gap counter to 0 and all outputs to 0, independent of i_clk.
REQ-026 Reset mid-transform SHALL discard progress; the first i_start after release begins at s=0, k=0.

Verification
REQ-027 GAP=2, no stall, start at cycle 0 -> valids at cycles 1-8, 11-18, 21-28, 31-38; o_done at 39; o_busy at 1-39.
REQ-028 Stage/address check -> s=1, k=5 gives idx_a=9, idx_b=11, tw=4; s=2, k=6 gives idx_a=10, idx_b=14, tw=4; s=3, k=7 gives idx_a=7, idx_b=15, tw=7; s=0 gives tw=0 always.
REQ-029 i_stall high for 3 cycles at s=1, k=3 -> o_bf_valid=0 for 3 cycles with outputs held; sequence resumes at k=3; done delayed by 3 cycles.
REQ-030 i_abort at s=2, k=4 -> IDLE next cycle with o_busy=0 and no o_done; a fresh i_start restarts at s=0, k=0.
REQ-031 i_start re-pulsed mid-run, and i_start together with i_abort in IDLE -> no effect on the sequence or state.
REQ-032 GAP=0 -> 32 consecutive valid cycles 1-32, o_done at 33; async i_rst asserted mid-cycle -> all outputs 0 before the next clock edge.
